// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared EX-stage operator constants and divider state encoding
package riscv_defines;

   localparam int MUL_OP_WIDTH = 3;
   localparam logic [MUL_OP_WIDTH-1:0] MUL_MAC32 = 3'b000;
   localparam logic [MUL_OP_WIDTH-1:0] MUL_MSU32 = 3'b001;
   localparam logic [MUL_OP_WIDTH-1:0] MUL_I     = 3'b010;
   localparam logic [MUL_OP_WIDTH-1:0] MUL_IR    = 3'b011;
   localparam logic [MUL_OP_WIDTH-1:0] MUL_DOT8  = 3'b100;
   localparam logic [MUL_OP_WIDTH-1:0] MUL_DOT16 = 3'b101;
   localparam logic [MUL_OP_WIDTH-1:0] MUL_H     = 3'b110;

   // bit 0 selects signed, bit 1 selects remainder
   localparam logic [1:0] DIV_DIVU = 2'b00;
   localparam logic [1:0] DIV_DIV  = 2'b01;
   localparam logic [1:0] DIV_REMU = 2'b10;
   localparam logic [1:0] DIV_REM  = 2'b11;

   localparam int DIV_STATE_WIDTH = 3;

   typedef enum logic [DIV_STATE_WIDTH-1:0] {
      DIV_IDLE,
      DIV_PREP,
      DIV_ITER,
      DIV_FIXUP,
      DIV_FINISH
   } div_state_e;

endpackage

// File: rtl/riscv_div_clz.sv
// rtl/riscv_div_clz.sv - 32-bit leading-zero counter, returns 32 for a zero input
module riscv_div_clz (
   input  logic [31:0] data,
   output logic [5:0]  count
);

   // scanning upward lets the most significant set bit have the final say
   always_comb begin
      count = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (data[i]) count = 6'(31 - i);
      end
   end

endmodule

// File: rtl/riscv_serial_div.sv
// rtl/riscv_serial_div.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU; RISCV_DIV_EARLY_OUT_EN skips leading zeros
module riscv_serial_div
   import riscv_defines::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_i,
   input  logic [1:0]  operator_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   output logic [31:0] result_o,
   output logic        multicycle_o,
   output logic        ready_o,
   input  logic        ex_ready_i
);

   div_state_e  state, state_next;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] divisor, dividend, quotient;
   logic [32:0] remainder, rem_shift;
   logic [4:0]  count;
   logic        neg_q, neg_r;

   logic        is_signed, div_zero, overflow, rem_ge;
   logic [31:0] abs_a, abs_b, quo_fix, rem_fix;

   always_comb begin
      is_signed = op_q[0];
      abs_a     = (is_signed && a_q[31]) ? -a_q : a_q;
      abs_b     = (is_signed && b_q[31]) ? -b_q : b_q;
      div_zero  = (b_q == 32'd0);
      overflow  = is_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
      rem_shift = {remainder[31:0], dividend[31]};
      rem_ge    = (rem_shift >= {1'b0, divisor});
      quo_fix   = neg_q ? -quotient : quotient;
      rem_fix   = neg_r ? -remainder[31:0] : remainder[31:0];
   end

`ifdef RISCV_DIV_EARLY_OUT_EN
   logic [5:0] lead_zeros;

   riscv_div_clz u_clz (
      .data  (abs_a),
      .count (lead_zeros)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= DIV_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next   = state;
      ready_o      = 1'b0;
      multicycle_o = 1'b0;
      case (state)
         DIV_IDLE: begin
            ready_o = !enable_i;
            if (enable_i) state_next = DIV_PREP;
         end
         DIV_PREP: begin
            multicycle_o = 1'b1;
            if (div_zero || overflow)
               state_next = DIV_FINISH;
`ifdef RISCV_DIV_EARLY_OUT_EN
            else if (lead_zeros == 6'd32)
               state_next = DIV_FIXUP;
`endif
            else
               state_next = DIV_ITER;
         end
         DIV_ITER: begin
            multicycle_o = 1'b1;
            if (count == 5'd0) state_next = DIV_FIXUP;
         end
         DIV_FIXUP: begin
            multicycle_o = 1'b1;
            state_next   = DIV_FINISH;
         end
         DIV_FINISH: begin
            ready_o = 1'b1;
            if (ex_ready_i) state_next = DIV_IDLE;
         end
         default: state_next = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= 2'b00;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         divisor   <= 32'd0;
         dividend  <= 32'd0;
         quotient  <= 32'd0;
         remainder <= 33'd0;
         count     <= 5'd0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         result_o  <= 32'd0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (enable_i) begin
                  op_q <= operator_i;
                  a_q  <= op_a_i;
                  b_q  <= op_b_i;
               end
            end
            DIV_PREP: begin
               neg_q     <= is_signed & (a_q[31] ^ b_q[31]);
               neg_r     <= is_signed & a_q[31];
               divisor   <= abs_b;
               remainder <= 33'd0;
               quotient  <= 32'd0;
`ifdef RISCV_DIV_EARLY_OUT_EN
               count     <= 5'(6'd31 - lead_zeros);
               dividend  <= abs_a << lead_zeros;
`else
               count     <= 5'd31;
               dividend  <= abs_a;
`endif
               // special cases bypass the iteration and publish straight away
               if (div_zero)
                  result_o <= op_q[1] ? a_q : 32'hFFFF_FFFF;
               else if (overflow)
                  result_o <= op_q[1] ? 32'd0 : 32'h8000_0000;
            end
            DIV_ITER: begin
               remainder <= rem_ge ? (rem_shift - {1'b0, divisor}) : rem_shift;
               quotient  <= {quotient[30:0], rem_ge};
               dividend  <= {dividend[30:0], 1'b0};
               count     <= count - 5'd1;
            end
            DIV_FIXUP: begin
               result_o <= op_q[1] ? rem_fix : quo_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_serial_div.sv
// tb/tb_riscv_serial_div.sv - randomized self-checking bench for riscv_serial_div
module tb_riscv_serial_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_i;
   logic [1:0]  operator_i;
   logic [31:0] op_a_i, op_b_i;
   logic [31:0] result_o;
   logic        multicycle_o, ready_o, ex_ready_i;

   int vectors     = 0;
   int miscompares = 0;

   logic        active = 1'b0;
   int          k      = 0;
   int          lat    = 0;
   logic [31:0] exp_res = 32'd0;

   always #5 clk = ~clk;

   riscv_serial_div dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .operator_i   (operator_i),
      .op_a_i       (op_a_i),
      .op_b_i       (op_b_i),
      .result_o     (result_o),
      .multicycle_o (multicycle_o),
      .ready_o      (ready_o),
      .ex_ready_i   (ex_ready_i)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic; the overflow case falls out of truncation
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   // cycles from the enable cycle to the first FINISH cycle
   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint mag;
      int     n;
      if (b == 32'd0) return 2;
      if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      mag = op[0] ? longint'($signed(a)) : longint'(a);
      if (mag < 0) mag = -mag;
      n = 0;
      while (mag != 0) begin
         n++;
         mag = mag >> 1;
      end
`ifdef RISCV_DIV_EARLY_OUT_EN
      return 3 + n;
`else
      return (n >= 0) ? 35 : 0;
`endif
   endfunction

   always @(negedge clk) begin
      if (active) begin
         if (k < 0) begin
            check("idle_ready", {31'd0, ready_o}, 32'd1);
            check("idle_multicycle", {31'd0, multicycle_o}, 32'd0);
         end else if (k == 0) begin
            check("accept_ready", {31'd0, ready_o}, 32'd0);
            check("accept_multicycle", {31'd0, multicycle_o}, 32'd0);
         end else if (k < lat) begin
            check("busy_ready", {31'd0, ready_o}, 32'd0);
            check("busy_multicycle", {31'd0, multicycle_o}, 32'd1);
         end else begin
            check("finish_ready", {31'd0, ready_o}, 32'd1);
            check("finish_multicycle", {31'd0, multicycle_o}, 32'd0);
            check("result", result_o, exp_res);
         end
      end
   end

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      operator_i = op;
      op_a_i     = a;
      op_b_i     = b;
      enable_i   = 1'b1;
      ex_ready_i = 1'b0;
      exp_res    = ref_div(op, a, b);
      lat        = ref_lat(op, a, b);
      k          = 0;
      active     = 1'b1;
      @(posedge clk); #1;
      enable_i   = 1'b0;
      op_a_i     = $urandom;
      op_b_i     = $urandom;
      operator_i = 2'($urandom);
      k          = 1;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit toggle);
      start_op(op, a, b);
      while (k < lat) begin
         @(posedge clk); #1;
         k++;
      end
      for (int h = 0; h < hold; h++) begin
         if (toggle) begin
            enable_i = ~enable_i;
            op_a_i   = $urandom;
         end
         @(posedge clk); #1;
         k++;
      end
      ex_ready_i = 1'b1;
      @(posedge clk); #1;
      ex_ready_i = 1'b0;
      enable_i   = 1'b0;
      k          = -1;
      @(posedge clk); #1;
      active = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand(input bit divisor_side);
      case ($urandom_range(0, 5))
         0: return divisor_side ? 32'd0 : 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'($urandom_range(0, 20));
         3: return divisor_side ? 32'd1 : 32'd0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst        = 1'b1;
      enable_i   = 1'b0;
      operator_i = 2'b00;
      op_a_i     = 32'd0;
      op_b_i     = 32'd0;
      ex_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_ready", {31'd0, ready_o}, 32'd1);
      check("reset_multicycle", {31'd0, multicycle_o}, 32'd0);
      check("reset_result", result_o, 32'd0);

      check("pin_divu_100_7", ref_div(2'b00, 32'd100, 32'd7), 32'd14);
      check("pin_div_m7_2", ref_div(2'b01, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("pin_rem_m7_2", ref_div(2'b11, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      check("pin_divu_big_2", ref_div(2'b00, 32'hFFFF_FFF9, 32'd2), 32'h7FFF_FFFC);
      check("pin_div_by0", ref_div(2'b01, 32'd5, 32'd0), 32'hFFFF_FFFF);
      check("pin_remu_by0", ref_div(2'b10, 32'd5, 32'd0), 32'd5);
      check("pin_div_ovf", ref_div(2'b01, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      check("pin_rem_ovf", ref_div(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
      check("pin_lat_by0", 32'(ref_lat(2'b01, 32'd5, 32'd0)), 32'd2);
      check("pin_lat_ovf", 32'(ref_lat(2'b11, 32'h8000_0000, 32'hFFFF_FFFF)), 32'd2);
`ifdef RISCV_DIV_EARLY_OUT_EN
      check("pin_divu_3_1", ref_div(2'b00, 32'd3, 32'd1), 32'd3);
      check("pin_lat_3_1", 32'(ref_lat(2'b00, 32'd3, 32'd1)), 32'd5);
`else
      check("pin_lat_normal", 32'(ref_lat(2'b00, 32'd100, 32'd7)), 32'd35);
`endif

      run_op(2'b00, 32'd100, 32'd7, 0, 1'b0);
      run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      run_op(2'b01, 32'd5, 32'd0, 0, 1'b0);
      run_op(2'b10, 32'd5, 32'd0, 0, 1'b0);
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(2'b00, 32'd3, 32'd1, 0, 1'b0);
      run_op(2'b10, 32'd0, 32'd9, 0, 1'b0);
      run_op(2'b00, 32'd1234567, 32'd89, 5, 1'b1);

      // reset during iteration discards the operation and clears the result
      start_op(2'b00, 32'hDEAD_BEEF, 32'd3);
      while (k < 11) begin
         @(posedge clk); #1;
         k++;
      end
      active = 1'b0;
      rst    = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_ready", {31'd0, ready_o}, 32'd1);
      check("rst_mid_multicycle", {31'd0, multicycle_o}, 32'd0);
      check("rst_mid_result", result_o, 32'd0);

      // reset and enable together: the request must not be taken
      @(posedge clk); #1;
      rst        = 1'b1;
      enable_i   = 1'b1;
      operator_i = 2'b01;
      op_a_i     = 32'd77;
      op_b_i     = 32'd5;
      @(posedge clk); #1;
      rst      = 1'b0;
      enable_i = 1'b0;
      @(negedge clk);
      check("rst_en_ready", {31'd0, ready_o}, 32'd1);
      check("rst_en_multicycle", {31'd0, multicycle_o}, 32'd0);
      @(negedge clk);
      check("rst_en_multicycle2", {31'd0, multicycle_o}, 32'd0);
      check("rst_en_result", result_o, 32'd0);

      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom_range(0, 3)), pick_operand(1'b0), pick_operand(1'b1),
                $urandom_range(0, 3), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
